// File: rtl/sink_apb_master_pkg.sv
// Shared AHB-to-APB bridge definitions: FSM states,
// request packet field positions and response width.
package sink_apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam int BR_ADDR_WIDTH = 32;
  localparam int BR_DATA_WIDTH = 32;

  localparam int DATA_MSB = BR_DATA_WIDTH - 1;
  localparam int ADDR_LSB = BR_DATA_WIDTH;
  localparam int ADDR_MSB =
    BR_DATA_WIDTH + BR_ADDR_WIDTH - 1;
  localparam int RW_BIT =
    BR_DATA_WIDTH + BR_ADDR_WIDTH + 1;

  function automatic int rsp_width(
    input int dw
  );
    return dw + 1;
  endfunction

endpackage

// File: rtl/sink_apb_master_if.sv
// Request/response FIFO ports and APB bus
// of the bridge sink side.
interface sink_apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import sink_apb_master_pkg::*;

  localparam int PW = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int RW = rsp_width(DATA_WIDTH);

  logic                  i_req_empty;
  logic [PW-1:0]         i_req_packet;
  logic                  o_req_rd_en;
  logic                  i_rsp_full;
  logic                  o_rsp_wr_en;
  logic [RW-1:0]         o_rsp_packet;
  logic                  o_psel;
  logic                  o_penable;
  logic                  o_pwrite;
  logic [ADDR_WIDTH-1:0] o_paddr;
  logic [DATA_WIDTH-1:0] o_pwdata;
  logic                  i_pready;
  logic                  i_pslverr;
  logic [DATA_WIDTH-1:0] i_prdata;

  modport master (
    input  i_req_empty, i_req_packet,
    input  i_rsp_full,
    input  i_pready, i_pslverr, i_prdata,
    output o_req_rd_en,
    output o_rsp_wr_en, o_rsp_packet,
    output o_psel, o_penable, o_pwrite,
    output o_paddr, o_pwdata
  );

  modport slave (
    output i_req_empty, i_req_packet,
    output i_rsp_full,
    output i_pready, i_pslverr, i_prdata,
    input  o_req_rd_en,
    input  o_rsp_wr_en, o_rsp_packet,
    input  o_psel, o_penable, o_pwrite,
    input  o_paddr, o_pwdata
  );

endinterface

// File: rtl/sink_apb_master_apb_timeout_counter.sv
// ACCESS-phase wait counter; built only
// with APB_TIMEOUT_EN defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/sink_apb_master.sv
// Sink-side APB master of the AHB-to-APB bridge.
// Define APB_TIMEOUT_EN to bound ACCESS wait states.
module sink_apb_master
  import sink_apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = BR_ADDR_WIDTH,
  parameter int DATA_WIDTH = BR_DATA_WIDTH,
  parameter int PACKET_WIDTH =
    ADDR_WIDTH + DATA_WIDTH + 2
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic i_clk_sink,
  input  logic i_rst_sink,
  input  logic i_sink_sleep_req,
  output logic o_sink_sleep_ack,
  output logic sink_sleep_status,
  sink_apb_master_if.master bus
);

  localparam int F_RW   = PACKET_WIDTH - 1;
  localparam int F_RSVD = PACKET_WIDTH - 2;
  localparam int F_AMSB = PACKET_WIDTH - 3;
  localparam int F_ALSB = DATA_WIDTH;
  localparam int F_DMSB = DATA_WIDTH - 1;
  localparam int RSP_W  = rsp_width(DATA_WIDTH);

  state_t state;
  state_t state_n;

  logic             sleep_q;
  logic             load;
  logic             cap;
  logic             done;
  logic             rd_en;
  logic             wr_en;
  logic [RSP_W-1:0] rsp_d;
  logic             unused_rsvd;

  assign unused_rsvd = bus.i_req_packet[F_RSVD];

`ifdef APB_TIMEOUT_EN
  logic expired;

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk_sink),
    .rst    (i_rst_sink),
    .clear  (state == SETUP),
    .inc    (state == ACCESS && !bus.i_pready),
    .expired(expired)
  );

  // A timed-out read reports a bus error
  assign done  = bus.i_pready | expired;
  assign rsp_d = bus.i_pready
    ? {bus.i_pslverr, bus.i_prdata}
    : {1'b1, {DATA_WIDTH{1'b0}}};
`else
  assign done  = bus.i_pready;
  assign rsp_d = {bus.i_pslverr, bus.i_prdata};
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    cap     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.i_req_empty &&
            !i_sink_sleep_req && !sleep_q) begin
          rd_en   = 1'b1;
          load    = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (done) begin
          cap     = !bus.o_pwrite;
          state_n = bus.o_pwrite ? IDLE : RESP;
        end
      end
      RESP: begin
        if (!bus.i_rsp_full) begin
          wr_en   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // No FIFO traffic on a reset edge
    if (i_rst_sink) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge i_clk_sink) begin
    if (i_rst_sink) begin
      state            <= IDLE;
      sleep_q          <= 1'b0;
      bus.o_paddr      <= '0;
      bus.o_pwdata     <= '0;
      bus.o_pwrite     <= 1'b0;
      bus.o_rsp_packet <= '0;
    end else begin
      state   <= state_n;
      sleep_q <= (state == IDLE) && i_sink_sleep_req;
      if (load) begin
        bus.o_paddr  <= bus.i_req_packet[F_AMSB:F_ALSB];
        bus.o_pwdata <= bus.i_req_packet[F_DMSB:0];
        bus.o_pwrite <= bus.i_req_packet[F_RW];
      end
      if (cap) begin
        bus.o_rsp_packet <= rsp_d;
      end
    end
  end

  assign bus.o_psel    = (state == SETUP) ||
                         (state == ACCESS);
  assign bus.o_penable = (state == ACCESS);
  assign bus.o_req_rd_en = rd_en;
  assign bus.o_rsp_wr_en = wr_en;
  assign o_sink_sleep_ack  = sleep_q;
  assign sink_sleep_status = sleep_q;

endmodule

// File: tb/tb_sink_apb_master.sv
// Self-checking bench for sink_apb_master against a
// transaction-level model of FIFOs, APB slave and sleep.
module tb_sink_apb_master;
  import sink_apb_master_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int PW  = AW + DW + 2;
  localparam int TMO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sleep_req;
  logic ack;
  logic status;

  sink_apb_master_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  sink_apb_master #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .PACKET_WIDTH(PW)
  ) dut (
    .i_clk_sink       (clk),
    .i_rst_sink       (rst),
    .i_sink_sleep_req (sleep_req),
    .o_sink_sleep_ack (ack),
    .sink_sleep_status(status),
    .bus              (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  req_t        q[$];
  req_t        issued[$];
  logic [32:0] exp_rsp[$];

  bit busy = 0;
  bit rsp_wait = 0;
  bit prev_rd = 0;
  bit exp_ack = 0;
  int acc_n = 0;
  int rsp_n = 0;
  int cur_wait = 0;
  int cur_hold = 0;
  int next_wait = 0;
  int next_hold = 0;
  bit fix_data = 0;
  logic [31:0] fix_rdata = '0;
  int err_ctl = 0;
  bit rand_sleep = 0;
  logic [32:0] last_pkt = '0;
  int last_acc = 0;
  int n_rsp = 0;
  int cyc = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(
    input req_t r
  );
    return {r.wr, 1'($urandom_range(0, 1)),
            r.addr, r.data};
  endfunction

  task automatic refresh_fifo();
    bus.i_req_empty = (q.size() == 0);
    if (q.size() > 0) bus.i_req_packet = pack(q[0]);
    else bus.i_req_packet = {$urandom, $urandom, 2'b0};
  endtask

  task automatic drive_inputs();
    refresh_fifo();
    bus.i_pready = (acc_n >= cur_wait);
    bus.i_prdata = fix_data ? fix_rdata : $urandom;
    bus.i_pslverr = (err_ctl == 2)
      ? 1'($urandom_range(0, 1)) : 1'(err_ctl);
    bus.i_rsp_full = rsp_wait && (rsp_n < cur_hold);
    if (rand_sleep)
      sleep_req = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push_req(
    input logic        wr,
    input logic [31:0] a,
    input logic [31:0] d
  );
    req_t r;
    r.wr = wr;
    r.addr = a;
    r.data = d;
    q.push_back(r);
    refresh_fifo();
  endtask

  task automatic cycle();
    logic s_rd, s_wr, s_psel, s_pen, s_pw;
    logic [31:0] s_pa, s_pd;
    logic [32:0] s_rp;
    bit e_rd, e_wr, e_psel, e_pen, tmo;
    bit busy_n, rsp_wait_n;
    int acc_n_n, rsp_n_n;
    req_t r;
    @(negedge clk);
    s_rd = bus.o_req_rd_en;
    s_wr = bus.o_rsp_wr_en;
    s_psel = bus.o_psel;
    s_pen = bus.o_penable;
    s_pw = bus.o_pwrite;
    s_pa = bus.o_paddr;
    s_pd = bus.o_pwdata;
    s_rp = bus.o_rsp_packet;
    busy_n = busy;
    rsp_wait_n = rsp_wait;
    acc_n_n = acc_n;
    rsp_n_n = rsp_n;
    if (rst) begin
      chk("rst_rd_en", s_rd, 0);
      chk("rst_wr_en", s_wr, 0);
      busy = 0;
      rsp_wait = 0;
      prev_rd = 0;
      exp_ack = 0;
      acc_n = 0;
      rsp_n = 0;
      issued.delete();
      exp_rsp.delete();
    end else begin
      e_rd = !busy && q.size() > 0 &&
             !sleep_req && !exp_ack;
      e_psel = busy && !rsp_wait;
      e_pen = e_psel && !prev_rd;
      chk("rd_en", s_rd, e_rd);
      chk("sleep_ack", ack, exp_ack);
      chk("sleep_status", status, exp_ack);
      chk("psel", s_psel, e_psel);
      chk("penable", s_pen, e_pen);
      if (e_pen) begin
        tmo = 0;
`ifdef APB_TIMEOUT_EN
        tmo = !bus.i_pready && (acc_n == TMO - 1);
`endif
        if (bus.i_pready || tmo) begin
          r = issued[0];
          chk("paddr", s_pa, r.addr);
          chk("pwrite", s_pw, r.wr);
          chk("pwdata", s_pd, r.data);
          if (r.wr) begin
            busy_n = 0;
          end else begin
            exp_rsp.push_back(tmo ? {1'b1, 32'h0}
              : {bus.i_pslverr, bus.i_prdata});
            rsp_wait_n = 1;
            rsp_n_n = 0;
          end
          issued.delete(0);
          last_acc = acc_n + 1;
          acc_n_n = 0;
        end else begin
          acc_n_n = acc_n + 1;
        end
      end
      e_wr = 0;
      if (rsp_wait) begin
        chk("rsp_hold", s_rp, exp_rsp[0]);
        e_wr = !bus.i_rsp_full;
        if (e_wr) begin
          last_pkt = s_rp;
          exp_rsp.delete(0);
          busy_n = 0;
          rsp_wait_n = 0;
          n_rsp++;
        end else begin
          rsp_n_n = rsp_n + 1;
        end
      end
      chk("wr_en", s_wr, e_wr);
      if (e_rd) begin
        issued.push_back(q[0]);
        busy_n = 1;
        acc_n_n = 0;
        cur_wait = (next_wait < 0)
          ? $urandom_range(0, 4) : next_wait;
        cur_hold = (next_hold < 0)
          ? $urandom_range(0, 3) : next_hold;
      end
      exp_ack = sleep_req && !busy;
      prev_rd = e_rd;
      busy = busy_n;
      rsp_wait = rsp_wait_n;
      acc_n = acc_n_n;
      rsp_n = rsp_n_n;
    end
    @(posedge clk);
    #1;
    if (s_rd && q.size() > 0) q.delete(0);
    drive_inputs();
  endtask

  task automatic drain(input int bound);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while ((q.size() > 0 || busy || rsp_wait)
               && cyc < bound);
    if (q.size() > 0 || busy || rsp_wait)
      chk("drain_bound", 0, 1);
  endtask

  task automatic wait_access(input int bound);
    int n = 0;
    while (!(bus.o_psel && bus.o_penable)
           && n < bound) begin
      cycle();
      n++;
    end
    if (!(bus.o_psel && bus.o_penable))
      chk("access_bound", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, bus.o_req_rd_en, 0);
    chk({tag, "_wr_en"}, bus.o_rsp_wr_en, 0);
    chk({tag, "_psel"}, bus.o_psel, 0);
    chk({tag, "_penable"}, bus.o_penable, 0);
    chk({tag, "_pwrite"}, bus.o_pwrite, 0);
    chk({tag, "_paddr"}, bus.o_paddr, 0);
    chk({tag, "_pwdata"}, bus.o_pwdata, 0);
    chk({tag, "_rsp_pkt"}, bus.o_rsp_packet, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_status"}, status, 0);
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    sleep_req = 1'b0;
    drive_inputs();
    repeat (3) cycle();
    chk_zero("reset");
    rst = 1'b0;

    // zero-wait posted write
    next_wait = 0;
    next_hold = 0;
    push_req(1'b1, 32'h10, 32'hDEAD_BEEF);
    drain(50);
    chk("wr_latency", cyc, 3);
    chk("wr_no_rsp", n_rsp, 0);
    chk("wr_paddr_kept", bus.o_paddr, 32'h10);
    chk("wr_pwdata_kept", bus.o_pwdata, 32'hDEAD_BEEF);

    // read with three wait states
    next_wait = 3;
    fix_data = 1;
    fix_rdata = 32'h1234_5678;
    err_ctl = 0;
    push_req(1'b0, 32'h20, $urandom);
    drain(50);
    chk("rd_latency", cyc, 7);
    chk("rd_access_cycles", last_acc, 4);
    chk("rd_pkt", last_pkt, 33'h0_1234_5678);
    chk("rd_rsp_count", n_rsp, 1);

    // response FIFO full for five RESP cycles
    next_wait = 0;
    next_hold = 5;
    fix_rdata = 32'hA5A5_0F0F;
    push_req(1'b0, 32'h30, $urandom);
    drain(50);
    chk("bp_latency", cyc, 9);
    chk("bp_pkt", last_pkt, 33'h0_A5A5_0F0F);
    err_ctl = 1;
    fix_rdata = 32'hCAFE_F00D;
    push_req(1'b0, 32'h34, $urandom);
    drain(50);
    chk("err_pkt", last_pkt, 33'h1_CAFE_F00D);
    chk("err_msb", last_pkt[32], 1);

    // back-to-back zero-wait writes
    next_hold = 0;
    err_ctl = 0;
    push_req(1'b1, 32'h40, 32'h1111_2222);
    push_req(1'b1, 32'h44, 32'h3333_4444);
    drain(50);
    chk("b2b_latency", cyc, 6);

    // sleep request raised during ACCESS
    next_wait = 3;
    err_ctl = 2;
    fix_data = 0;
    push_req(1'b0, 32'h100, $urandom);
    push_req(1'b1, 32'h104, $urandom);
    push_req(1'b0, 32'h108, $urandom);
    wait_access(20);
    sleep_req = 1'b1;
    repeat (15) cycle();
    chk("sleep_granted", ack, 1);
    chk("sleep_queue_held", q.size(), 2);
    sleep_req = 1'b0;
    drain(80);
    chk("sleep_queue_done", q.size(), 0);

    // reset while a read is in ACCESS
    next_wait = 100;
    r0 = n_rsp;
    push_req(1'b0, 32'h200, $urandom);
    wait_access(20);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk_zero("midrst");
    rst = 1'b0;
    next_wait = 0;
    repeat (10) cycle();
    chk("midrst_no_rsp", n_rsp, r0);

    // randomized traffic with sleep toggling
    next_wait = -1;
    next_hold = -1;
    err_ctl = 2;
    rand_sleep = 1;
    for (int i = 0; i < 40; i++)
      push_req(1'($urandom_range(0, 1)),
               $urandom, $urandom);
    drain(3000);
    rand_sleep = 0;
    sleep_req = 1'b0;
    repeat (3) cycle();

`ifdef APB_TIMEOUT_EN
    // read with pready stuck low
    next_wait = 1000;
    next_hold = 0;
    push_req(1'b0, 32'h300, $urandom);
    drain(100);
    chk("tmo_access_cycles", last_acc, TMO);
    chk("tmo_pkt", last_pkt, 33'h1_0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sink_apb_master.md
Name: sink_apb_master

Overview:
- Sink-side controller of the AHB-to-APB bridge.
- Pops request packets from the sink read port of the request async FIFO and runs each one as an APB transfer.
- For reads, pushes a response packet {pslverr, prdata} into the sink write port of the response async FIFO.
- Runs entirely in the sink (APB) clock domain and owns the sink half of the sleep handshake.

Parameters:
- ADDR_WIDTH, 32, APB address width; equals the request packet address field width.
- DATA_WIDTH, 32, APB data width.
- PACKET_WIDTH, ADDR_WIDTH+DATA_WIDTH+2, request packet width.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- i_clk_sink  in  1  sink clock.
- i_rst_sink  in  1  reset, synchronous, active-high.
- i_sink_sleep_req  in  1  sleep request.
- o_sink_sleep_ack  out  1  sleep granted.
- sink_sleep_status  out  1  sink idle-and-sleeping status, sent to the source.
- i_req_empty  in  1  request FIFO empty.
- i_req_packet  in  PACKET_WIDTH  request FIFO head; first-word fall-through, valid while !i_req_empty.
- o_req_rd_en  out  1  request FIFO pop, single-cycle pulse.
- i_rsp_full  in  1  response FIFO full.
- o_rsp_wr_en  out  1  response FIFO push, single-cycle pulse.
- o_rsp_packet  out  DATA_WIDTH+1  {pslverr, prdata}.
- o_psel, o_penable, o_pwrite  out  1 each  APB control.
- o_paddr  out  ADDR_WIDTH  APB address.
- o_pwdata  out  DATA_WIDTH  APB write data.
- i_pready, i_pslverr  in  1 each  APB completion and error.
- i_prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Request packet fields: [PW-1]=rd0_wr1; [PW-2] reserved, ignored; [PW-3:DATA_WIDTH]=addr; [DATA_WIDTH-1:0]=wdata.
- Reset, when i_rst_sink=1 at a clock edge: every output goes to 0 and the FSM goes to IDLE. This applies mid-transfer too; the in-flight transfer is dropped and no FIFO push or pop occurs in that cycle.
- IDLE:
  - If !i_req_empty and not sleeping: latch addr/wdata/rd0_wr1 into o_paddr/o_pwdata/o_pwrite, pulse o_req_rd_en for 1 cycle, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: o_psel=1, o_penable=0, then ACCESS unconditionally.
- ACCESS:
  - o_psel=1, o_penable=1.
  - On i_pready=1: capture i_prdata and i_pslverr into o_rsp_packet (reads only); drop o_psel/o_penable next cycle.
  - After completion, a write goes to IDLE and a read goes to RESP.
  - i_pready=0 holds ACCESS indefinitely unless the timeout feature is compiled in.
- RESP:
  - If !i_rsp_full: pulse o_rsp_wr_en for 1 cycle, go to IDLE.
  - If i_rsp_full: hold o_rsp_packet stable and wait.
- Writes are posted: they produce no response packet, and i_pslverr on a write is discarded.
- o_paddr, o_pwdata and o_pwrite stay stable from SETUP through completion. After completion they hold their last values; they are not cleared.
- Latency:
  - Write, zero-wait: 3 cycles per transfer (IDLE, SETUP, ACCESS).
  - Read, zero-wait, response FIFO not full: 4 cycles (adds RESP).
  - Back-to-back requests: the next pop happens in the IDLE cycle right after completion.
- Sleep:
  - Sleep is granted only in IDLE: when i_sink_sleep_req=1 in IDLE, o_sink_sleep_ack=1 and sink_sleep_status=1 from the next cycle.
  - A request arriving mid-transfer is granted only after the transfer, including its RESP, finishes.
  - While acked, no pop occurs even if the request FIFO is non-empty.
  - Deasserting i_sink_sleep_req clears ack and status next cycle; fetching resumes the cycle after that.
- Simultaneous sleep request and non-empty FIFO in IDLE: sleep wins and no pop occurs.
- o_req_rd_en and o_rsp_wr_en are never asserted in the same cycle.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with i_pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with i_pready still 0, the transfer completes as if i_pready=1 with pslverr forced to 1 and prdata forced to 0.
  - A read completed this way goes to RESP. A write completed this way goes to IDLE.
- Undefined: no counter; ACCESS waits for i_pready without limit.

Decomposition:
- Shared bridge package holds:
  - FSM state enum {IDLE, SETUP, ACCESS, RESP}.
  - Packet field bit-position localparams (RW_BIT, ADDR_LSB, ADDR_MSB, DATA_MSB).
  - The response packet width function DATA_WIDTH+1.
  - These same definitions are reused by source_controller.
- One natural sub-module: apb_timeout_counter, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write: push {wr=1, addr=0x0000_0010, data=0xDEAD_BEEF} with i_pready tied to 1.
  - o_psel rises 1 cycle after the pop; o_penable follows 1 cycle later.
  - o_paddr=0x10, o_pwdata=0xDEADBEEF, o_pwrite=1.
  - No o_rsp_wr_en.
- Read with wait states: push {wr=0, addr=0x20}; hold i_pready=0 for 3 ACCESS cycles, then 1 with i_prdata=0x1234_5678 and i_pslverr=0.
  - One o_rsp_wr_en with o_rsp_packet=0x0_1234_5678.
- Response backpressure: read completes with i_rsp_full=1 held for 5 cycles.
  - FSM stays in RESP with the packet stable; o_rsp_wr_en pulses in the first cycle after i_rsp_full drops.
  - Error variant with i_pslverr=1: o_rsp_packet MSB=1.
- Sleep: assert i_sink_sleep_req during ACCESS with 2 more requests queued.
  - Ack arrives after the current transfer; no further pop while acked.
  - Deassert the request: both queued transfers then run in order.
- Reset mid-ACCESS: assert i_rst_sink.
  - All outputs 0 next cycle, FSM in IDLE.
  - No o_rsp_wr_en for the aborted read.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16: read with i_pready stuck at 0.
  - Completion after exactly 16 ACCESS cycles; o_rsp_packet={1, 0x0000_0000}.
